// File: rtl/srdl_reg_access_ctrl.sv
// Round-robin access sequencer for a bank of srdlField registers (IDLE/ACC/RESP).
// Optional: define SRDL_ACC_ERR_EN to report out-of-range accesses on mX_err.
module srdl_reg_access_ctrl #(
  parameter int NREGS = 8,
  parameter int AW    = 3,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [AW-1:0]       m0_addr,
  input  logic [DW-1:0]       m0_wdata,
  output logic                m0_ack,
  output logic                m0_err,
  output logic [DW-1:0]       m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [AW-1:0]       m1_addr,
  input  logic [DW-1:0]       m1_wdata,
  output logic                m1_ack,
  output logic                m1_err,
  output logic [DW-1:0]       m1_rdata,
  output logic [NREGS-1:0]    reg_acc,
  output logic [NREGS-1:0]    reg_rd,
  output logic [NREGS-1:0]    reg_wr,
  output logic [DW-1:0]       reg_wdata,
  input  logic [NREGS*DW-1:0] reg_rdata
);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             gnt_q, gnt_d;
  logic [NREGS-1:0] acc_q, acc_d;
  logic [NREGS-1:0] rd_q, rd_d;
  logic [NREGS-1:0] wr_q, wr_d;
  logic [DW-1:0]    wout_q, wout_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       err_q, err_d;
  logic [DW-1:0]    rdata0_q, rdata0_d;
  logic [DW-1:0]    rdata1_q, rdata1_d;

  logic             sel;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [NREGS-1:0] dec;
  logic [DW-1:0]    rd_word;

  always_comb begin
    // last_q names the previous winner; the other side wins a tie
    sel      = (m0_req && m1_req) ? ~last_q : m1_req;
    sel_we   = sel ? m1_we : m0_we;
    sel_addr = sel ? m1_addr : m0_addr;
    dec      = '0;
    for (int i = 0; i < NREGS; i++) begin
      dec[i] = (sel_addr == AW'(i));
    end
    rd_word = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_q[i]) rd_word = reg_rdata[i*DW +: DW];
    end

    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    acc_d    = '0;
    rd_d     = '0;
    wr_d     = '0;
    wout_d   = '0;
    ack_d    = '0;
    err_d    = '0;
    rdata0_d = '0;
    rdata1_d = '0;

    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          gnt_d   = sel;
          last_d  = sel;
          acc_d   = dec;
          rd_d    = sel_we ? '0 : dec;
          wr_d    = sel_we ? dec : '0;
          wout_d  = sel ? m1_wdata : m0_wdata;
          state_d = ACC;
        end
      end
      ACC: begin
        ack_d[gnt_q] = 1'b1;
`ifdef SRDL_ACC_ERR_EN
        err_d[gnt_q] = ~|acc_q;
`endif
        if (gnt_q) rdata1_d = rd_word;
        else       rdata0_d = rd_word;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      acc_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      wout_q   <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      acc_q    <= acc_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wout_q   <= wout_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign reg_acc   = acc_q;
  assign reg_rd    = rd_q;
  assign reg_wr    = wr_q;
  assign reg_wdata = wout_q;
  assign m0_ack    = ack_q[0];
  assign m1_ack    = ack_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_srdl_reg_access_ctrl.sv
// Directed bench for srdl_reg_access_ctrl with a six-register bank model;
// register 1 behaves as a read-clear field.
module tb_srdl_reg_access_ctrl;
  localparam int NREGS = 6;
  localparam int AW    = 3;
  localparam int DW    = 32;
`ifdef SRDL_ACC_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0]       m0_addr, m1_addr;
  logic [DW-1:0]       m0_wdata, m1_wdata;
  logic                m0_ack, m0_err, m1_ack, m1_err;
  logic [DW-1:0]       m0_rdata, m1_rdata;
  logic [NREGS-1:0]    reg_acc, reg_rd, reg_wr;
  logic [DW-1:0]       reg_wdata;
  logic [NREGS*DW-1:0] reg_rdata;

  logic [DW-1:0]       bank [NREGS];
  logic                ld_en;
  logic [2:0]          ld_idx;
  logic [DW-1:0]       ld_val;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  srdl_reg_access_ctrl #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .m1_rdata(m1_rdata),
    .reg_acc(reg_acc), .reg_rd(reg_rd), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  always_comb begin
    reg_rdata = '0;
    for (int i = 0; i < NREGS; i++) reg_rdata[i*DW +: DW] = bank[i];
  end

  always @(posedge clk) begin
    if (ld_en) bank[ld_idx] <= ld_val;
    else begin
      for (int i = 0; i < NREGS; i++) begin
        if (reg_wr[i]) bank[i] <= reg_wdata;
        else if (i == 1 && reg_rd[i]) bank[i] <= '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic txn(input bit port, input bit we, input logic [AW-1:0] a,
                     input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd,
                     input logic exp_err, input string tag);
    logic [NREGS-1:0] oh;
    oh = '0;
    if (a < NREGS) oh[a] = 1'b1;
    @(negedge clk);
    if (port) begin
      m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = wd;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = wd;
    end
    @(posedge clk); #1;
    chk({tag, ".acc"}, 64'(reg_acc), 64'(oh));
    chk({tag, ".rd"}, 64'(reg_rd), we ? 64'(0) : 64'(oh));
    chk({tag, ".wr"}, 64'(reg_wr), we ? 64'(oh) : 64'(0));
    chk({tag, ".wdata"}, 64'(reg_wdata), 64'(wd));
    chk({tag, ".early_ack"}, 64'({m1_ack, m0_ack}), 64'(0));
    @(posedge clk); #1;
    chk({tag, ".ack"}, 64'({m1_ack, m0_ack}), port ? 64'(2) : 64'(1));
    chk({tag, ".rdata"}, 64'(port ? m1_rdata : m0_rdata), 64'(exp_rd));
    chk({tag, ".err"}, 64'(port ? m1_err : m0_err), 64'(exp_err));
    chk({tag, ".other"}, 64'(port ? m0_rdata : m1_rdata), 64'(0));
    chk({tag, ".strobe_off"}, 64'({reg_acc, reg_wdata}), 64'(0));
    @(negedge clk);
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    logic [DW-1:0] init_val [NREGS];
    bit p;
    init_val = '{32'h0, 32'hA5, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    rst = 1'b1; ld_en = 1'b0; ld_idx = '0; ld_val = '0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ack", 64'({m1_ack, m0_ack, m1_err, m0_err}), 64'(0));
    chk("rst.rdata", 64'({m1_rdata, m0_rdata}), 64'(0));
    chk("rst.strobes", 64'({reg_acc, reg_rd, reg_wr}), 64'(0));
    chk("rst.wdata", 64'(reg_wdata), 64'(0));

    for (int i = 0; i < NREGS; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_idx = 3'(i); ld_val = init_val[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
    rst = 1'b0;

    txn(1'b0, 1'b0, 3'd2, 32'h0,    32'hDEADBEEF, 1'b0,    "rd2");
    txn(1'b1, 1'b1, 3'd5, 32'h1234, 32'h0,        1'b0,    "wr5");
    txn(1'b0, 1'b0, 3'd5, 32'h0,    32'h1234,     1'b0,    "rb5");
    txn(1'b0, 1'b0, 3'd7, 32'h0,    32'h0,        EXP_ERR, "oor_rd");
    txn(1'b1, 1'b1, 3'd6, 32'hCAFE, 32'h0,        EXP_ERR, "oor_wr");
    txn(1'b1, 1'b0, 3'd1, 32'h0,    32'hA5,       1'b0,    "rclr1");
    txn(1'b0, 1'b0, 3'd1, 32'h0,    32'h0,        1'b0,    "rclr2");

    // both requesters held from reset: grants must alternate m0, m1
    @(negedge clk);
    rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 3'd2;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 3'd5;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      p = (k % 2) == 1;
      @(posedge clk); #1;
      chk("rr.acc", 64'(reg_acc), p ? 64'h20 : 64'h04);
      chk("rr.acc_noack", 64'({m1_ack, m0_ack}), 64'(0));
      @(posedge clk); #1;
      chk("rr.ack", 64'({m1_ack, m0_ack}), p ? 64'(2) : 64'(1));
      chk("rr.rdata", 64'(p ? m1_rdata : m0_rdata),
          p ? 64'h1234 : 64'hDEADBEEF);
      chk("rr.resp_nostrobe", 64'(reg_acc), 64'(0));
      @(posedge clk); #1;
      chk("rr.idle", 64'({reg_acc, m1_ack, m0_ack}), 64'(0));
    end
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk);

    // reset lands mid-ACC: the write is lost, m1 then wins alone
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 3'd3; m0_wdata = 32'h5555;
    @(posedge clk); #1;
    chk("racc.acc", 64'(reg_acc), 64'h08);
    #2 rst = 1'b1;
    #1;
    chk("racc.strobes", 64'({reg_acc, reg_wr}), 64'(0));
    chk("racc.wdata", 64'(reg_wdata), 64'(0));
    @(negedge clk);
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 3'd5;
    @(posedge clk); #1;
    chk("racc.noack", 64'({m1_ack, m0_ack}), 64'(0));
    chk("racc.lost_write", 64'(bank[3]), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("racc.m1_acc", 64'(reg_acc), 64'h20);
    @(posedge clk); #1;
    chk("racc.m1_ack", 64'({m1_ack, m0_ack}), 64'(2));
    chk("racc.m1_rdata", 64'(m1_rdata), 64'h1234);
    @(negedge clk);
    m1_req = 1'b0;
    @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
